sub_bytes_serial: RTL



---
 rtl/sub_bytes_serial.sv | 105 ++++++++++
 1 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES SubBytes through one registered S-box; define SUB_BYTES_SHIFTROWS_EN to fuse ShiftRows into write-back
module sbox (
  input  logic       clk,
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry 0 sits at the MSB end, so index from the top: offset 8*(255-x).
  always_ff @(posedge clk) o_out <= SBOX[{~i_in, 3'b000} +: 8];
endmodule

module sub_bytes_serial (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       r_state;
  logic [127:0] r_in, r_out;
  logic [3:0]   r_rd, r_wi;
  logic         r_issue, r_wv, r_out_valid, r_busy;
  logic [7:0]   w_sb_in, w_sb_out;
  logic [3:0]   w_dst;

  assign w_sb_in   = r_in[{r_rd, 3'b000} +: 8];
`ifdef SUB_BYTES_SHIFTROWS_EN
  // Input (r,c) lands at output (r,(c-r)%4); the 2-bit subtract wraps mod 4.
  assign w_dst     = {r_wi[3:2] - r_wi[1:0], r_wi[1:0]};
`else
  assign w_dst     = r_wi;
`endif
  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign busy      = r_busy;

  sbox u_sbox (.clk(clk), .i_in(w_sb_in), .o_out(w_sb_out));

  // Control FSM, byte issue counter, write-tag pipeline and output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in        <= '0;
      r_out       <= '0;
      r_rd        <= '0;
      r_wi        <= '0;
      r_issue     <= 1'b0;
      r_wv        <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wv <= r_issue;
      r_wi <= r_rd;
      case (r_state)
        IDLE: if (in_valid) begin
          r_in    <= in_data;
          r_rd    <= '0;
          r_issue <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          if (r_issue) begin
            r_rd <= r_rd + 4'd1;
            if (r_rd == 4'd15) r_issue <= 1'b0;
          end
          if (r_wv) r_out[{w_dst, 3'b000} +: 8] <= w_sb_out;
          if (r_wv && r_wi == 4'd15) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
